// File: rtl/trivium_seq_ctrl_if.sv
// Bundle between the Trivium session sequencer and its environment
// (command logic, Trivium core, shared up/down counter, keystream consumer).
interface trivium_seq_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 16
) ();
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] num_words;
    logic                 core_load;
    logic                 core_en;
    logic                 ks_valid;
    logic                 ks_ready;
    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_din;
    logic                 cnt_down;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 busy;
    logic                 done;

    // Sequencer side
    modport slave (
        input  start, abort, num_words, ks_ready, cnt_q,
        output core_load, core_en, ks_valid, cnt_load, cnt_din, cnt_down, busy, done
    );

    // Environment side
    modport master (
        output start, abort, num_words, ks_ready, cnt_q,
        input  core_load, core_en, ks_valid, cnt_load, cnt_din, cnt_down, busy, done
    );
endinterface

// File: rtl/trivium_seq_ctrl.sv
// Trivium keystream session sequencer: loads key/IV, times the warm-up rounds
// and the keystream word count with an external loadable down counter.
module trivium_seq_ctrl #(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned WARMUP_CYCLES = 1152
) (
    input  logic               clk,
    input  logic               rst,
    trivium_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StWarmup = 3'd2,
        StRun    = 3'd3,
        StDone   = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] WarmupLoad = CNT_WIDTH'(WARMUP_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] nw_q, nw_d;

    logic                 core_load, core_en, ks_valid, cnt_load, cnt_down, busy, done;
    logic [CNT_WIDTH-1:0] cnt_din;

    // State and latched word count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            nw_q    <= '0;
        end else begin
            state_q <= state_d;
            nw_q    <= nw_d;
        end
    end

    // Next-state and output decode; abort overrides everything in busy states
    always_comb begin
        state_d   = state_q;
        nw_d      = nw_q;
        core_load = 1'b0;
        core_en   = 1'b0;
        ks_valid  = 1'b0;
        cnt_load  = 1'b0;
        cnt_din   = '0;
        cnt_down  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    nw_d    = bus.num_words;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                busy      = 1'b1;
                core_load = 1'b1;
                cnt_load  = 1'b1;
                cnt_din   = WarmupLoad;
                state_d   = StWarmup;
            end
            StWarmup: begin
                busy     = 1'b1;
                core_en  = 1'b1;
                cnt_down = 1'b1;
                // Last warm-up round: reload with the word count (load wins over down)
                if (bus.cnt_q == '0) begin
                    cnt_load = 1'b1;
                    cnt_din  = nw_q;
                    state_d  = (nw_q == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                busy     = 1'b1;
                ks_valid = 1'b1;
                core_en  = bus.ks_ready;
                cnt_down = bus.ks_ready;
                if (bus.ks_ready && bus.cnt_q == CNT_WIDTH'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (busy && bus.abort) begin
            state_d   = StIdle;
            core_load = 1'b0;
            core_en   = 1'b0;
            ks_valid  = 1'b0;
            cnt_down  = 1'b0;
            done      = 1'b0;
            cnt_load  = 1'b1;
            cnt_din   = '0;
        end
    end

    assign bus.core_load = core_load;
    assign bus.core_en   = core_en;
    assign bus.ks_valid  = ks_valid;
    assign bus.cnt_load  = cnt_load;
    assign bus.cnt_din   = cnt_din;
    assign bus.cnt_down  = cnt_down;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_trivium_seq_ctrl.sv
// Bench for trivium_seq_ctrl: two instances (short and default warm-up), each
// with a behavioural model of the shared counter; keystream handshakes are
// checked against a queue of expected word indices.
module tb_trivium_seq_ctrl;

    localparam int unsigned CW = 16;
    localparam int unsigned WA = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    trivium_seq_ctrl_if #(.CNT_WIDTH(CW)) ifa ();
    trivium_seq_ctrl_if #(.CNT_WIDTH(CW)) ifb ();

    trivium_seq_ctrl #(.CNT_WIDTH(CW), .WARMUP_CYCLES(WA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    trivium_seq_ctrl #(.CNT_WIDTH(CW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Counter models: registered, load has priority over down
    logic [CW-1:0] cnt_a, cnt_b;
    assign ifa.cnt_q = cnt_a;
    assign ifb.cnt_q = cnt_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt_a <= '0;
        else if (ifa.cnt_load) cnt_a <= ifa.cnt_din;
        else if (ifa.cnt_down) cnt_a <= cnt_a - 1'b1;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt_b <= '0;
        else if (ifb.cnt_load) cnt_b <= ifb.cnt_din;
        else if (ifb.cnt_down) cnt_b <= cnt_b - 1'b1;
    end

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    // One cycle on instance A: drive inputs after the falling edge, settle, return
    task automatic step_a(input logic st, input logic ab, input logic rdy, input logic [CW-1:0] nw);
        @(negedge clk);
        ifa.start = st; ifa.abort = ab; ifa.ks_ready = rdy; ifa.num_words = nw;
        #1;
    endtask

    task automatic step_b(input logic st, input logic rdy, input logic [CW-1:0] nw);
        @(negedge clk);
        ifb.start = st; ifb.abort = 1'b0; ifb.ks_ready = rdy; ifb.num_words = nw;
        #1;
    endtask

    task automatic test_reset();
        ifa.start = 0; ifa.abort = 0; ifa.ks_ready = 0; ifa.num_words = '0;
        ifb.start = 0; ifb.abort = 0; ifb.ks_ready = 0; ifb.num_words = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({ifa.core_load, ifa.core_en, ifa.ks_valid, ifa.cnt_load, ifa.cnt_down,
             ifa.busy, ifa.done} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl_a: got %b expected 0000000",
                {ifa.core_load, ifa.core_en, ifa.ks_valid, ifa.cnt_load, ifa.cnt_down,
                 ifa.busy, ifa.done});
        end
        checks++;
        if (ifa.cnt_din !== '0) begin
            errors++; $display("FAIL reset_din_a: got %0d expected 0", ifa.cnt_din);
        end
        checks++;
        if ({ifb.busy, ifb.core_en, ifb.cnt_load} !== 3'b0) begin
            errors++; $display("FAIL reset_ctrl_b: got %b expected 000",
                {ifb.busy, ifb.core_en, ifb.cnt_load});
        end
        @(negedge clk);
        rst = 1'b1;
        step_a(0, 0, 0, '0);
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++; $display("FAIL idle_busy: got %b expected 0", ifa.busy);
        end
    endtask

    task automatic test_zero_words();
        int load_c = -1, en_n = 0, en_first = -1, en_last = -1, done_c = -1;
        int v_n = 0, busy_n = 0, busy_first = -1, busy_last = -1;
        step_a(1, 0, 0, '0);
        checks++;
        if (ifa.busy !== 1'b0 || ifa.core_load !== 1'b0) begin
            errors++; $display("FAIL zero_c0: got busy=%b load=%b expected 0 0",
                ifa.busy, ifa.core_load);
        end
        for (int c = 1; c <= 14; c++) begin
            step_a(c == 10, 0, 0, '0);  // start in the DONE cycle must be ignored
            if (ifa.core_load) load_c = c;
            if (ifa.core_en) begin en_n++; if (en_first < 0) en_first = c; en_last = c; end
            if (ifa.ks_valid) v_n++;
            if (ifa.done) done_c = c;
            if (ifa.busy) begin busy_n++; if (busy_first < 0) busy_first = c; busy_last = c; end
        end
        checks++;
        if (load_c !== 1) begin errors++; $display("FAIL zero_load: got %0d expected 1", load_c); end
        checks++;
        if (en_n !== 8 || en_first !== 2 || en_last !== 9) begin
            errors++; $display("FAIL zero_en: got n=%0d %0d..%0d expected n=8 2..9",
                en_n, en_first, en_last);
        end
        checks++;
        if (done_c !== 10) begin errors++; $display("FAIL zero_done: got %0d expected 10", done_c); end
        checks++;
        if (v_n !== 0) begin errors++; $display("FAIL zero_valid: got %0d expected 0", v_n); end
        checks++;
        if (busy_n !== 10 || busy_first !== 1 || busy_last !== 10) begin
            errors++; $display("FAIL zero_busy: got n=%0d %0d..%0d expected n=10 1..10",
                busy_n, busy_first, busy_last);
        end
    endtask

    task automatic test_stream();
        int en_n = 0, hs_n = 0, v_first = -1, v_last = -1, done_c = -1, idx, e;
        for (int k = 0; k < 5; k++) exp_q.push_back(k);
        step_a(1, 0, 1, CW'(5));
        for (int c = 1; c <= 20; c++) begin
            step_a(0, 0, 1, '0);
            if (ifa.core_en) en_n++;
            if (ifa.ks_valid) begin if (v_first < 0) v_first = c; v_last = c; end
            if (ifa.done) done_c = c;
            if (ifa.ks_valid && ifa.ks_ready) begin
                hs_n++;
                idx = 5 - int'(cnt_a);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_hs: got index %0d expected none", idx);
                end else begin
                    e = exp_q.pop_front();
                    if (idx !== e) begin
                        errors++; $display("FAIL stream_word: got %0d expected %0d", idx, e);
                    end
                end
            end
        end
        checks++;
        if (v_first !== 10 || v_last !== 14) begin
            errors++; $display("FAIL stream_valid: got %0d..%0d expected 10..14", v_first, v_last);
        end
        checks++;
        if (done_c !== 15) begin errors++; $display("FAIL stream_done: got %0d expected 15", done_c); end
        checks++;
        if (hs_n !== 5 || exp_q.size() !== 0) begin
            errors++; $display("FAIL stream_hs: got %0d left %0d expected 5 left 0", hs_n, exp_q.size());
        end
        checks++;
        if (en_n !== 13) begin errors++; $display("FAIL stream_en: got %0d expected 13", en_n); end
        exp_q.delete();
    endtask

    task automatic test_ready_toggle();
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic rdy;
        int hs_n = 0, done_c = -1, last_hs = -1, idx, e, wrap = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(k);
        step_a(1, 0, 0, CW'(4));
        for (int c = 1; c <= 22; c++) begin
            rdy = (c < 10) ? 1'b0 : (c - 10 < 7) ? pat[c - 10] : 1'b1;
            step_a(0, 0, rdy, '0);
            if (cnt_a == '1) wrap++;
            if (ifa.done) done_c = c;
            if (ifa.ks_valid) begin
                checks++;
                if (ifa.core_en !== rdy || ifa.cnt_down !== rdy) begin
                    errors++; $display("FAIL toggle_track c%0d: got en=%b down=%b expected %b",
                        c, ifa.core_en, ifa.cnt_down, rdy);
                end
            end
            if (ifa.ks_valid && ifa.ks_ready) begin
                hs_n++; last_hs = c;
                idx = 4 - int'(cnt_a);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL toggle_extra_hs: got index %0d expected none", idx);
                end else begin
                    e = exp_q.pop_front();
                    if (idx !== e) begin
                        errors++; $display("FAIL toggle_word: got %0d expected %0d", idx, e);
                    end
                end
            end
        end
        checks++;
        if (hs_n !== 4 || last_hs !== 16 || done_c !== 17) begin
            errors++; $display("FAIL toggle_done: got hs=%0d last=%0d done=%0d expected 4 16 17",
                hs_n, last_hs, done_c);
        end
        checks++;
        if (wrap !== 0) begin errors++; $display("FAIL toggle_wrap: got %0d expected 0", wrap); end
        exp_q.delete();
    endtask

    task automatic test_default_warmup();
        int en_pre = 0, v_first = -1, hs_n = 0, done_c = -1;
        step_b(1, 1, CW'(1));
        for (int c = 1; c <= 1170; c++) begin
            step_b(0, 1, '0);
            if (ifb.ks_valid && v_first < 0) v_first = c;
            if (ifb.core_en && v_first < 0) en_pre++;
            if (ifb.ks_valid && ifb.ks_ready) hs_n++;
            if (ifb.done) done_c = c;
        end
        checks++;
        if (en_pre !== 1152 || v_first !== 1154) begin
            errors++; $display("FAIL dflt_warmup: got en=%0d first=%0d expected 1152 1154",
                en_pre, v_first);
        end
        checks++;
        if (hs_n !== 1 || done_c !== 1155) begin
            errors++; $display("FAIL dflt_done: got hs=%0d done=%0d expected 1 1155", hs_n, done_c);
        end
    endtask

    task automatic test_abort_warmup();
        int busy_n = 0, done_n = 0;
        step_a(1, 0, 0, CW'(5));
        for (int c = 1; c <= 15; c++) begin
            step_a(c == 3, c == 5, 0, CW'(5));
            if (c == 5) begin
                checks++;
                if (ifa.cnt_load !== 1'b1 || ifa.cnt_din !== '0 || ifa.core_en !== 1'b0 ||
                    ifa.cnt_down !== 1'b0) begin
                    errors++; $display("FAIL abort_w_cycle: got load=%b din=%0d en=%b down=%b expected 1 0 0 0",
                        ifa.cnt_load, ifa.cnt_din, ifa.core_en, ifa.cnt_down);
                end
            end
            if (c > 5 && ifa.busy) busy_n++;
            if (ifa.done) done_n++;
        end
        checks++;
        if (busy_n !== 0 || done_n !== 0) begin
            errors++; $display("FAIL abort_w_after: got busy=%0d done=%0d expected 0 0", busy_n, done_n);
        end
    endtask

    task automatic test_abort_run();
        int hs_n = 0, busy_n = 0, done_n = 0, idx, e;
        for (int k = 0; k < 2; k++) exp_q.push_back(k);
        step_a(1, 0, 1, CW'(5));
        for (int c = 1; c <= 20; c++) begin
            step_a(c == 11, c == 12, 1, CW'(5));
            if (c == 12) begin
                checks++;
                if (ifa.ks_valid !== 1'b0 || ifa.cnt_load !== 1'b1 || ifa.cnt_din !== '0 ||
                    ifa.core_en !== 1'b0 || ifa.cnt_down !== 1'b0) begin
                    errors++; $display("FAIL abort_r_cycle: got v=%b load=%b din=%0d en=%b down=%b expected 0 1 0 0 0",
                        ifa.ks_valid, ifa.cnt_load, ifa.cnt_din, ifa.core_en, ifa.cnt_down);
                end
            end
            if (ifa.ks_valid && ifa.ks_ready) begin
                hs_n++;
                idx = 5 - int'(cnt_a);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL abort_r_extra_hs: got index %0d expected none", idx);
                end else begin
                    e = exp_q.pop_front();
                    if (idx !== e) begin
                        errors++; $display("FAIL abort_r_word: got %0d expected %0d", idx, e);
                    end
                end
            end
            if (c > 12 && ifa.busy) busy_n++;
            if (ifa.done) done_n++;
        end
        checks++;
        if (hs_n !== 2 || busy_n !== 0 || done_n !== 0) begin
            errors++; $display("FAIL abort_r_after: got hs=%0d busy=%0d done=%0d expected 2 0 0",
                hs_n, busy_n, done_n);
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        int hs_n = 0, done_c = -1;
        step_a(1, 0, 1, CW'(5));
        for (int c = 1; c <= 11; c++) step_a(0, 0, 1, '0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ifa.busy, ifa.ks_valid, ifa.core_en, ifa.cnt_down, ifa.cnt_load} !== 5'b0) begin
            errors++; $display("FAIL async_rst: got %b expected 00000",
                {ifa.busy, ifa.ks_valid, ifa.core_en, ifa.cnt_down, ifa.cnt_load});
        end
        @(negedge clk);
        rst = 1'b1;
        step_a(1, 0, 1, CW'(3));
        for (int c = 1; c <= 16; c++) begin
            step_a(0, 0, 1, '0);
            if (ifa.ks_valid && ifa.ks_ready) hs_n++;
            if (ifa.done) done_c = c;
        end
        checks++;
        if (hs_n !== 3 || done_c !== 13) begin
            errors++; $display("FAIL async_resume: got hs=%0d done=%0d expected 3 13", hs_n, done_c);
        end
    endtask

    initial begin
        test_reset();
        test_zero_words();
        test_stream();
        test_ready_toggle();
        test_abort_warmup();
        test_abort_run();
        test_async_reset();
        test_default_warmup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
